// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// spi_reg_slave : SPI mode-0 slave (16-bit frames) exposing a 4-byte control
//                 bank, a 4-byte status window and an ID byte. Rev 1.0
// ============================================================================
module spi_reg_slave #(
  parameter logic [7:0]  ID_VALUE   = 8'hA5,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic        clk_base_i,
  input  logic        reset_i,
  input  logic        sclk_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [31:0] status_in_i,
  output logic [31:0] ctrl_out_o,
  output logic        wr_pulse_o,
  output logic [1:0]  wr_addr_o,
  output logic        frame_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic [2:0]  sclk_sync_q;
  logic [2:0]  ss_sync_q;
  logic [2:0]  mosi_sync_q;
  logic        rise_q;
  logic        fall_q;
  logic        ss_fall_q;
  logic        ss_rise_q;
  logic [1:0]  settle_q;
  logic        armed_q;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  rx_q;
  logic [7:0]  tx_q;
  logic        rw_q;
  logic [6:0]  addr_q;
  logic        miso_q;
  logic        miso_oe_q;
  logic [31:0] ctrl_q;
  logic        wr_pulse_q;
  logic [1:0]  wr_addr_q;
  logic        frame_err_q;

  logic [7:0]  rx_d;
  logic [7:0]  ctrl_byte_d;
  logic [7:0]  stat_byte_d;
  logic [7:0]  rd_data_d;

  // After reset the SS_N pipeline holds its idle level, so a select that was
  // already low would look like a fresh falling edge; armed_q blocks frame
  // starts until a genuine synchronized high level has been observed.
  always_ff @(posedge clk_base_i) begin
    if (reset_i) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
      ss_sync_q   <= {ss_sync_q[1:0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[1:0], mosi_i};
      rise_q      <= sclk_sync_q[1] & ~sclk_sync_q[2];
      fall_q      <= ~sclk_sync_q[1] & sclk_sync_q[2];
      ss_fall_q   <= ~ss_sync_q[1] & ss_sync_q[2];
      ss_rise_q   <= ss_sync_q[1] & ~ss_sync_q[2];
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      if ((settle_q == 2'd3) && ss_sync_q[2]) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rx_d = {rx_q[6:0], mosi_sync_q[2]};
    ctrl_byte_d = 8'h00;
    stat_byte_d = 8'h00;
    case (rx_d[1:0])
      2'd0: begin ctrl_byte_d = ctrl_q[7:0];   stat_byte_d = status_in_i[7:0];   end
      2'd1: begin ctrl_byte_d = ctrl_q[15:8];  stat_byte_d = status_in_i[15:8];  end
      2'd2: begin ctrl_byte_d = ctrl_q[23:16]; stat_byte_d = status_in_i[23:16]; end
      default: begin ctrl_byte_d = ctrl_q[31:24]; stat_byte_d = status_in_i[31:24]; end
    endcase
    if (rx_d[6:2] == 5'd0) begin
      rd_data_d = ctrl_byte_d;
    end else if (rx_d[6:2] == 5'd1) begin
      rd_data_d = stat_byte_d;
    end else if (rx_d[6:0] == 7'h7F) begin
      rd_data_d = ID_VALUE;
    end else begin
      rd_data_d = 8'h00;
    end
  end

  always_ff @(posedge clk_base_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 7'h00;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      ctrl_q      <= CTRL_RESET;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= 2'd0;
      frame_err_q <= 1'b0;
    end else begin
      wr_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          if (ss_fall_q && armed_q) begin
            state_q   <= S_CMD;
            bit_cnt_q <= 4'd0;
            rx_q      <= 8'h00;
            miso_oe_q <= 1'b1;
          end
        end
        S_CMD: begin
          if (ss_rise_q) begin
            state_q     <= S_IDLE;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (rise_q) begin
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rw_q    <= rx_d[7];
              addr_q  <= rx_d[6:0];
              tx_q    <= rd_data_d;
              miso_q  <= rd_data_d[7];
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (ss_rise_q) begin
            state_q     <= S_IDLE;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            frame_err_q <= 1'b1;
          end else begin
            // The MSB is already on the line from the 8th rise, so the fall
            // that immediately follows it must not shift.
            if (fall_q && (bit_cnt_q != 4'd8)) begin
              tx_q   <= {tx_q[6:0], 1'b0};
              miso_q <= tx_q[6];
            end
            if (rise_q) begin
              rx_q <= rx_d;
              if (bit_cnt_q == 4'd15) begin
                state_q <= S_DONE;
                miso_q  <= 1'b0;
                if (!rw_q) begin
                  if (addr_q[6:2] == 5'd0) begin
                    wr_pulse_q <= 1'b1;
                    wr_addr_q  <= addr_q[1:0];
                    case (addr_q[1:0])
                      2'd0:    ctrl_q[7:0]   <= rx_d;
                      2'd1:    ctrl_q[15:8]  <= rx_d;
                      2'd2:    ctrl_q[23:16] <= rx_d;
                      default: ctrl_q[31:24] <= rx_d;
                    endcase
                  end else if (addr_q == 7'h7E) begin
                    frame_err_q <= 1'b0;
                  end
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end
        end
        default: begin
          miso_q <= 1'b0;
          if (ss_sync_q[2]) begin
            state_q   <= S_IDLE;
            miso_oe_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = miso_oe_q;
  assign ctrl_out_o  = ctrl_q;
  assign wr_pulse_o  = wr_pulse_q;
  assign wr_addr_o   = wr_addr_q;
  assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: doc/spi_reg_slave.md
# spi_reg_slave

Fabric-side SPI slave register bank. It is driven by the MSS SPI_0 master: MSS SPI_0_CLK, SPI_0_SS0 and SPI_0_DO feed this block, and its MISO drives MSS SPI_0_DI. Firmware on the Cortex-M3 uses it to write fabric control bytes and read fabric status bytes over a 16-bit framed protocol. All SPI inputs are oversampled on the fabric CCC clock (FAB_CCC_GL0).

## Interface
- ID_VALUE, 8'hA5: constant returned when address 0x7F is read.
- CTRL_RESET, 32'h0000_0000: reset value of the four control bytes.
- CLK_BASE  in  1: fabric clock (FAB_CCC_GL0). Must be at least 8× the SCLK frequency.
- RESET  in  1: synchronous, active-high reset.
- SCLK  in  1: SPI clock from MSS SPI_0_CLK. Asynchronous. Mode 0 (CPOL=0, CPHA=0).
- SS_N  in  1: slave select from MSS SPI_0_SS0, active-low. Asynchronous.
- MOSI  in  1: from MSS SPI_0_DO. Asynchronous.
- MISO  out  1: to MSS SPI_0_DI.
- MISO_OE  out  1: high while a frame is active.
- STATUS_IN  in  32: fabric status. Byte k is read at address 4+k.
- CTRL_OUT  out  32: control register bytes. Byte k is at address k.
- WR_PULSE  out  1: one-cycle strobe when a control byte is committed.
- WR_ADDR  out  2: byte index of the last commit.
- FRAME_ERR  out  1: sticky; set on an aborted frame. Cleared by RESET or by a write to address 0x7E.

## Operation
- Synchronizers: SCLK, SS_N and MOSI each pass through 2 flops, plus a third flop for edge detection. rise/fall = one-cycle pulses on synchronized SCLK edges. ss_fall = pulse on the synchronized SS_N falling edge.
- Frame: SS_N low, then 16 bits, MSB first. Byte 0 = {RW, ADDR[6:0]}; RW=1 is read. Byte 1 = write data (RW=0) or don't-care (RW=1).
- FSM states:
  - IDLE → CMD on ss_fall. Clears bit counter, rx shift register and MISO.
  - CMD: shift MOSI into rx on each rise. On the 8th rise, latch RW/ADDR, load tx with read data, drive MISO = tx[7], → DATA.
  - DATA: on each fall, shift tx left and MISO = new tx[7]. On each rise, shift rx. On the 16th rise → DONE, with commit if RW=0.
  - DONE: ignore all further edges until SS_N is high (synchronized) → IDLE.
- Read data map, sampled at the 8th rise:
  - 0x00–0x03: CTRL_OUT byte.
  - 0x04–0x07: STATUS_IN byte.
  - 0x7F: ID_VALUE.
  - All others: 0x00.
- Write commit at the 16th rise:
  - ADDR 0x00–0x03: update the CTRL_OUT byte, WR_PULSE=1, WR_ADDR=ADDR[1:0].
  - ADDR 0x7E: clear FRAME_ERR, no WR_PULSE.
  - All other addresses: discarded silently, no WR_PULSE.
- Abort: synchronized SS_N rising in CMD or DATA → IDLE. No commit, FRAME_ERR=1. SS_N rising in DONE is a normal end.
- MISO_OE = 1 in CMD/DATA/DONE. MISO = 0 whenever not in DATA.
- Bit counter: 4 bits, no wrap. Extra SCLKs after bit 16 have no effect.
- Reset values: MISO=0, MISO_OE=0, CTRL_OUT=CTRL_RESET, WR_PULSE=0, WR_ADDR=0, FRAME_ERR=0, FSM=IDLE, synchronizer flops = idle levels (SCLK 0, SS_N 1).
- RESET mid-frame returns to IDLE immediately without setting FRAME_ERR. The remainder of that frame is ignored until SS_N goes high and then low again.

## Timing
- Input to pulse latency: 3 CLK_BASE cycles from a raw SCLK/SS_N edge to the rise/fall/ss_fall pulse.
- Commit: CTRL_OUT byte and WR_PULSE change in the cycle after the 16th rise pulse, i.e. 4 cycles after the raw 16th SCLK rising edge. WR_PULSE is exactly 1 cycle wide.
- MISO valid timing: MISO changes at most 4 CLK_BASE cycles after the raw SCLK falling edge (or after the 8th rising edge for the MSB). It is therefore valid before the next rising edge when SCLK half-period ≥ 4 CLK_BASE.
- SS setup: at least 4 CLK_BASE cycles between SS_N falling and the first SCLK rising edge.
- SS deselect gap: at least 4 CLK_BASE cycles high between frames.
- Simultaneous rise and SS_N deassert in the same cycle: SS_N wins and the frame is aborted.
- STATUS_IN is treated as quasi-static and is sampled once per read frame.

## Test plan
- Write 0x02 ← 0x3C (MOSI 0x02,0x3C; SCLK = CLK/8) → CTRL_OUT[23:16]=0x3C. One WR_PULSE with WR_ADDR=2, 4 cycles after the 16th raw rise. Other bytes unchanged.
- Read 0x7F → MISO shifts 0xA5 MSB-first, each bit valid at its rising edge. No WR_PULSE.
- STATUS_IN=32'h1122_3344, read 0x05 → 0x33. Read 0x10 → 0x00. Write 0x10 ← 0xFF → no WR_PULSE, CTRL_OUT unchanged.
- Write 0x01 ← 0x77 with SS_N raised after 11 bits → CTRL_OUT unchanged, FRAME_ERR=1. Next full write to 0x7E → FRAME_ERR=0. Next normal write succeeds.
- 20 SCLKs in one frame writing 0x00 ← 0x81 → single commit of 0x81 to byte 0. Bits 17–20 are ignored.
- Assert RESET during bit 10 of a write → all outputs at reset values next cycle. Frame is ignored. Subsequent frame after an SS_N high period works normally.
